// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage.
// Takes the current PC and issues a single-outstanding read to instruction
// memory. Fetched {pc, instr} pairs go into a circular queue that decode
// drains through a valid/ready handshake. The block returns next-PC, stall and
// branch strobes to the PC register.
// Optional build macro IFETCH_PERF_EN adds the perf_wait_cnt output, which
// counts memory wait cycles.
module ifetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_cur,
  output logic [AW-1:0] pc_next,
  output logic          pc_stall,
  output logic          pc_exec,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]   perf_wait_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_REDIR} state_t;

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_addr;
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic [AW-1:0]  r_q_pc   [DEPTH];
  logic [DW-1:0]  r_q_data [DEPTH];
  logic           w_issue, w_push, w_pop, w_full;

  assign w_full   = (r_count == CW'(DEPTH));
  assign ir_valid = (r_count != '0);
  assign ir_pc    = r_q_pc[r_rptr];
  assign ir_data  = r_q_data[r_rptr];
  assign w_pop    = ir_valid & ir_ready;
  // A branch kills any ack arriving in the same cycle, so the push is gated by it.
  assign w_push   = (r_state == S_WAIT) & imem_ack & ~br_taken;

  assign pc_next   = br_taken ? br_target : pc_cur + AW'(1);
  assign pc_exec   = br_taken;
  assign imem_req  = (r_state == S_WAIT) || (r_state == S_DROP);
  assign imem_addr = r_addr;
  assign pc_stall  = ~(w_push | (r_state == S_REDIR));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic. A branch always lands in S_REDIR, but it first waits out
  // any outstanding read so that a stale ack cannot be mistaken for new data.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (br_taken) w_state_nxt = S_REDIR;
        else if (!w_full) begin
          w_state_nxt = S_WAIT;
          w_issue     = 1'b1;
        end
      end
      S_WAIT: begin
        if (br_taken)      w_state_nxt = imem_ack ? S_REDIR : S_DROP;
        else if (imem_ack) w_state_nxt = S_IDLE;
      end
      S_DROP:  if (imem_ack) w_state_nxt = S_REDIR;
      S_REDIR: if (!br_taken) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read address is captured at issue and held until the ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_addr <= '0;
    else if (w_issue) r_addr <= pc_cur;
  end

  // Queue pointers and occupancy. A branch flushes the queue; a pop in the same
  // cycle has already been taken by decode, so dropping everything is correct.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (br_taken) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage. Contents need no reset because ir_valid qualifies them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wptr]   <= r_addr;
      r_q_data[r_wptr] <= imem_rdata;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] r_perf;
  assign perf_wait_cnt = r_perf;

  // Saturating count of cycles spent waiting on memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perf <= '0;
    else if (imem_req && !imem_ack && r_perf != 16'hFFFF) r_perf <= r_perf + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit. The bench models the PC register and the memory
// around the DUT. A reference model predicts the instruction stream that
// decode should see: sequential addresses, redirected by each branch, with
// data equal to a fixed function of the address.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cur, pc_next, br_target, imem_addr, imem_rdata, ir_data, ir_pc;
  logic        pc_stall, pc_exec, br_taken, imem_req, imem_ack, ir_valid, ir_ready;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_wait_cnt;
`endif

  ifetch_unit #(.DEPTH(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_stall(pc_stall),
    .pc_exec(pc_exec), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_data(ir_data),
`ifdef IFETCH_PERF_EN
    .perf_wait_cnt(perf_wait_cnt),
`endif
    .ir_pc(ir_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_pops = 0;
  // memory model
  logic        mem_busy;
  int          mem_cnt, mem_lat;
  // PC register model (pending branch target)
  logic [15:0] pend;
  logic        pend_v;
  // stream reference
  logic [15:0] exp_pc;
  // per-cycle snapshots
  logic        o_req, o_stall, o_exec, o_ack, o_valid;
  logic [15:0] o_addr, o_irpc, o_irdata, o_pcnext;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  // One clock cycle: drive the inputs just after a negedge, snapshot at +1,
  // update the environment models, then advance to the next negedge.
  task automatic run_cycle(input logic br, input logic [15:0] tgt, input logic rdy);
    logic [15:0] nxt;
    br_taken = br; br_target = tgt; ir_ready = rdy;
    imem_ack = 1'b0; imem_rdata = 16'(($urandom));
    if (imem_req) begin
      if (!mem_busy) begin mem_busy = 1'b1; mem_cnt = mem_lat; end
      if (mem_cnt == 0) begin
        imem_ack = 1'b1; imem_rdata = mem_f(imem_addr); mem_busy = 1'b0;
      end else mem_cnt--;
    end
    #1;
    o_req = imem_req; o_addr = imem_addr; o_stall = pc_stall; o_exec = pc_exec;
    o_ack = imem_ack; o_valid = ir_valid; o_irpc = ir_pc; o_irdata = ir_data;
    o_pcnext = pc_next;
    n_tests++;
    if (pc_exec !== br) begin n_fail++; $display("FAIL pc_exec got %b want %b", pc_exec, br); end
    n_tests++;
    if (pc_next !== (br ? tgt : pc_cur + 16'd1)) begin
      n_fail++; $display("FAIL pc_next got %h want %h", pc_next, br ? tgt : pc_cur + 16'd1);
    end
    if (ir_valid && ir_ready) begin
      n_pops++;
      n_tests++;
      if (ir_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc got %h want %h", ir_pc, exp_pc); end
      n_tests++;
      if (ir_data !== mem_f(ir_pc)) begin
        n_fail++; $display("FAIL stream_data got %h want %h", ir_data, mem_f(ir_pc));
      end
      exp_pc = ir_pc + 16'd1;
    end
    if (br) exp_pc = tgt;
    nxt = pc_cur;
    if (br) begin pend = tgt; pend_v = 1'b1; end
    else if (!pc_stall) begin nxt = pend_v ? pend : pc_next; pend_v = 1'b0; end
    @(posedge clk);
    @(negedge clk);
    pc_cur = nxt;
  endtask

  task automatic do_reset(input logic [15:0] pc);
    rst = 1'b0; br_taken = 1'b0; br_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    ir_ready = 1'b0; pc_cur = pc; mem_busy = 1'b0; mem_cnt = 0; pend_v = 1'b0;
    pend = '0; exp_pc = pc;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; br_taken = 1'b0; br_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    ir_ready = 1'b0; pc_cur = 16'hFFFF; mem_busy = 1'b0; pend_v = 1'b0; pend = '0;
    exp_pc = 16'hFFFF; mem_lat = 0;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ir_valid); end
    n_tests++; if (imem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
    n_tests++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got %b want 1", pc_stall); end
    rst = 1'b1;
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b want 0", o_req); end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL c1_req got %b want 1", o_req); end
    n_tests++; if (o_addr !== 16'hFFFF) begin n_fail++; $display("FAIL c1_addr got %h want FFFF", o_addr); end
    n_tests++; if (o_pcnext !== 16'h0000) begin n_fail++; $display("FAIL wrap_pcnext got %h want 0000", o_pcnext); end
    n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL c1_stall got %b want 0", o_stall); end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL c2_valid got %b want 1", o_valid); end
    n_tests++; if (o_irpc !== 16'hFFFF) begin n_fail++; $display("FAIL c2_irpc got %h want FFFF", o_irpc); end
    n_tests++; if (o_irdata !== 16'h5A4A) begin n_fail++; $display("FAIL c2_irdata got %h want 5A4A", o_irdata); end
  endtask

  task automatic test_latency();
    do_reset(16'h0010); mem_lat = 2;
    run_cycle(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, 16'h0, 1'b0);
      n_tests++; if (o_stall !== 1'b1 || o_req !== 1'b1 || o_addr !== 16'h0010) begin
        n_fail++; $display("FAIL lat_wait%0d stall=%b req=%b addr=%h want 1 1 0010", i, o_stall, o_req, o_addr);
      end
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_ack !== 1'b1 || o_stall !== 1'b0) begin
      n_fail++; $display("FAIL lat_ack ack=%b stall=%b want 1 0", o_ack, o_stall);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_valid !== 1'b1 || o_irpc !== 16'h0010 || o_irdata !== 16'hA5A5) begin
      n_fail++; $display("FAIL lat_head valid=%b pc=%h data=%h want 1 0010 A5A5", o_valid, o_irpc, o_irdata);
    end
`ifdef IFETCH_PERF_EN
    n_tests++; if (perf_wait_cnt !== 16'd2) begin
      n_fail++; $display("FAIL perf_cnt got %0d want 2", perf_wait_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset(16'h0100); mem_lat = 0;
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 16'h0, 1'b0);
      n_tests++; if (o_req !== 1'b0 || o_stall !== 1'b1) begin
        n_fail++; $display("FAIL full_hold%0d req=%b stall=%b want 0 1", i, o_req, o_stall);
      end
    end
    run_cycle(1'b0, 16'h0, 1'b1);
    n_tests++; if (o_irpc !== 16'h0100 || o_req !== 1'b0) begin
      n_fail++; $display("FAIL pop0 pc=%h req=%b want 0100 0", o_irpc, o_req);
    end
    run_cycle(1'b0, 16'h0, 1'b1);
    n_tests++; if (o_irpc !== 16'h0101) begin n_fail++; $display("FAIL pop1 pc=%h want 0101", o_irpc); end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b1 || o_addr !== 16'h0102) begin
      n_fail++; $display("FAIL resume req=%b addr=%h want 1 0102", o_req, o_addr);
    end
  endtask

  task automatic test_branch_wait();
    do_reset(16'h0020); mem_lat = 0;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'h0, 1'b0);
    mem_lat = 3;
    run_cycle(1'b1, 16'h0040, 1'b0);
    n_tests++; if (o_exec !== 1'b1 || o_stall !== 1'b1 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL brw_cyc exec=%b stall=%b valid=%b want 1 1 1", o_exec, o_stall, o_valid);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_exec !== 1'b0 || o_valid !== 1'b0 || o_req !== 1'b1) begin
      n_fail++; $display("FAIL brw_flush exec=%b valid=%b req=%b want 0 0 1", o_exec, o_valid, o_req);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_ack !== 1'b1 || o_stall !== 1'b1) begin
      n_fail++; $display("FAIL brw_lateack ack=%b stall=%b want 1 1", o_ack, o_stall);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_stall !== 1'b0 || o_req !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL brw_redir stall=%b req=%b valid=%b want 0 0 0", o_stall, o_req, o_valid);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL brw_nopush valid=%b want 0", o_valid); end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b1 || o_addr !== 16'h0040) begin
      n_fail++; $display("FAIL brw_target req=%b addr=%h want 1 0040", o_req, o_addr);
    end
  endtask

  task automatic test_branch_ack_pop();
    do_reset(16'h0030); mem_lat = 0;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'h0, 1'b0);
    run_cycle(1'b1, 16'h0050, 1'b1);
    n_tests++; if (o_ack !== 1'b1 || o_valid !== 1'b1 || o_irpc !== 16'h0030 || o_stall !== 1'b1) begin
      n_fail++; $display("FAIL bap_cyc ack=%b valid=%b pc=%h stall=%b want 1 1 0030 1", o_ack, o_valid, o_irpc, o_stall);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_req !== 1'b0) begin
      n_fail++; $display("FAIL bap_redir valid=%b stall=%b req=%b want 0 0 0", o_valid, o_stall, o_req);
    end
    run_cycle(1'b0, 16'h0, 1'b0);
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b1 || o_addr !== 16'h0050) begin
      n_fail++; $display("FAIL bap_target req=%b addr=%h want 1 0050", o_req, o_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(16'h0200); mem_lat = 0;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'h0, 1'b0);
    mem_lat = 5;
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (imem_req !== 1'b1 || ir_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre req=%b valid=%b want 1 1", imem_req, ir_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== 16'h0) begin
      n_fail++; $display("FAIL mid_async req=%b valid=%b addr=%h want 0 0 0000", imem_req, ir_valid, imem_addr);
    end
    do_reset(16'h0300); mem_lat = 0;
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL mid_idle req=%b want 0", o_req); end
    run_cycle(1'b0, 16'h0, 1'b0);
    n_tests++; if (o_req !== 1'b1 || o_addr !== 16'h0300) begin
      n_fail++; $display("FAIL mid_restart req=%b addr=%h want 1 0300", o_req, o_addr);
    end
  endtask

  task automatic test_random();
    int pops0;
    do_reset(16'(($urandom)));
    pops0 = n_pops;
    for (int i = 0; i < 1500; i++) begin
      mem_lat = $urandom_range(0, 3);
      run_cycle($urandom_range(0, 15) == 0, 16'(($urandom)), $urandom_range(0, 3) != 0);
    end
    n_tests++; if (n_pops - pops0 < 100) begin
      n_fail++; $display("FAIL rand_progress pops=%0d want >=100", n_pops - pops0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_branch_wait();
    test_branch_ack_pop();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
